fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the program counter and issues word-aligned requests to instruction memory.
- Registers each returned instruction with its PC into the IF/ID pipeline register that drives decode's 32-bit instruction input.
- Handles decode stalls with a one-entry holding buffer, and branch redirects with a flush.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: instruction (addi x0,x0,0) driven on instr_out whenever the stage holds a bubble.

Ports:
- clk  input  1  stage clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address, equal to the internal PC
- imem_ready  input  1  same-cycle response strobe; imem_rdata is valid when imem_req & imem_ready
- imem_rdata  input  32  fetched instruction word
- stall  input  1  decode/hazard unit asks IF/ID to hold
- branch_taken  input  1  redirect request from the branch unit
- branch_target  input  32  redirect address
- instr_out  output  32  IF/ID instruction, feeds decode
- pc_out  output  32  PC of instr_out
- valid_out  output  1  instr_out is a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=BOOT, imem_req=0, instr_out=NOP_INSTR, pc_out=0, valid_out=0, hold buffer empty. Asserting reset mid-fetch or mid-stall discards everything immediately.
- imem_addr = pc, combinationally, at all times. imem_req is 1 only in state FETCH.
- A fetch is accepted when imem_req & imem_ready. Latency is one cycle: the word accepted at edge N appears on instr_out after edge N.
- State BOOT: one cycle after reset release with no request, then go to FETCH. branch_taken in BOOT loads pc=branch_target and still goes to FETCH.
- State FETCH:
  - Accepted & !stall: instr_out<=imem_rdata, pc_out<=pc, valid_out<=1, pc<=pc+4.
  - Accepted & stall: IF/ID outputs hold; buf<=imem_rdata, buf_pc<=pc, pc<=pc+4, go to HOLD.
  - Not accepted & !stall: instr_out<=NOP_INSTR, valid_out<=0 (bubble); pc_out holds.
  - Not accepted & stall: all outputs hold; pc holds.
- State HOLD: imem_req=0.
  - stall=1: all outputs hold.
  - stall=0: instr_out<=buf, pc_out<=buf_pc, valid_out<=1, go to FETCH.
- branch_taken has highest priority in every state and overrides stall:
  - pc<=branch_target, instr_out<=NOP_INSTR, valid_out<=0, buffer discarded, go to FETCH.
  - Any imem response in that same cycle is dropped.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- With FETCH_MISALIGN_CHECK_EN undefined, branch_target[1:0] is forced to 2'b00 when loaded.
- IF/ID outputs change only on a clock edge or on reset; they never glitch combinationally.
- Three-state FSM: BOOT, FETCH, HOLD. No other states exist; unreachable encodings return to FETCH.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- When defined:
  - Adds output port misaligned (1 bit, reset 0).
  - A redirect with branch_target[1:0]!=0 sets misaligned=1 (sticky until reset) and loads pc=branch_target unmodified.
  - The FSM enters a fourth state HALT: imem_req=0, instr_out=NOP_INSTR, valid_out=0, and later branch_taken is ignored.
- When undefined:
  - No misaligned port and no HALT state.
  - Target low bits are cleared as described under Behaviour.

Test Plan:
- Release reset with imem_ready=1 tied high and rdata = address-tagged words → BOOT cycle, then instr_out/pc_out = (word@0,0), (word@4,4), (word@8,8) on consecutive cycles, valid_out=1.
- imem_ready low for 2 cycles at pc=8 → two bubbles (instr_out=32'h0000_0013, valid_out=0); pc stays 8; resumes with word@8.
- stall high for 3 cycles while imem_ready=1 at pc=12 → outputs hold word@8; word@12 buffered; imem_req=0 for 2 cycles; after stall drops, instr_out=word@12 then word@16. No instruction is lost or duplicated.
- branch_taken with branch_target=32'h0000_0100 during HOLD with stall=1 → next cycle valid_out=0, NOP on instr_out, imem_addr=0x100; buffered word is never emitted.
- RESET_PC=32'hFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- branch_target=32'h0000_0102 → undefined macro: imem_addr=0x100. Defined macro: misaligned=1, imem_req=0, valid_out=0 until reset.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting directly upstream of decode. It owns the
// program counter, issues word-aligned requests to instruction memory and
// registers each returned word, together with its PC, into the IF/ID
// register that feeds decode.
//
// Decode stalls are absorbed by a one-entry holding buffer. A word that
// memory returns while decode is stalled is parked there and released once
// the stall clears. Branch redirects flush the IF/ID register and the
// buffer, and they take priority over everything else.
//
// Parameters:
//   RESET_PC   - PC value loaded on reset
//   NOP_INSTR  - instruction driven on instr_out whenever the stage holds
//                a bubble
//
// Ports:
//   clk            in   stage clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_req       out  fetch request valid (only in FETCH)
//   imem_addr      out  fetch address, always equal to the internal PC
//   imem_ready     in   same-cycle response strobe
//   imem_rdata     in   fetched word, valid when imem_req & imem_ready
//   stall          in   decode asks IF/ID to hold
//   branch_taken   in   redirect request
//   branch_target  in   redirect address
//   instr_out      out  IF/ID instruction
//   pc_out         out  PC of instr_out
//   valid_out      out  instr_out is a real instruction (0 = bubble)
//   misaligned     out  sticky misaligned-redirect flag
//                       (only with FETCH_MISALIGN_CHECK_EN defined)
//
// Handshake: a fetch is accepted in any cycle where imem_req and
// imem_ready are both high on the rising edge. imem_rdata is consumed on
// that same edge, and no response is expected in a later cycle.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   Undefined: redirect targets have bits [1:0] cleared.
//   Defined:   a redirect to a target that is not word-aligned raises the
//              sticky misaligned flag and parks the stage in HALT until
//              reset. No fetches are issued and later redirects are ignored.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        accepted;
  logic        halted;
  logic        redirect_bad;
  logic [31:0] redirect_pc;

  assign imem_addr = pc;
  assign imem_req  = (state == ST_FETCH);
  assign accepted  = imem_req & imem_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  // A misaligned target is kept unmodified so the faulting address stays
  // visible on imem_addr while the stage is halted.
  assign halted       = (state == ST_HALT);
  assign redirect_bad = (branch_target[1:0] != 2'b00);
  assign redirect_pc  = branch_target;
`else
  assign halted       = 1'b0;
  assign redirect_bad = 1'b0;
  assign redirect_pc  = branch_target & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      buf_instr  <= NOP_INSTR;
      buf_pc     <= 32'h0000_0000;
      instr_out  <= NOP_INSTR;
      pc_out     <= 32'h0000_0000;
      valid_out  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else if (halted) begin
      // Terminal until reset. The bubble on IF/ID was loaded on entry.
      state <= state;
    end else if (branch_taken) begin
      // A redirect beats stall and drops any response from this cycle.
      // The buffer is discarded by leaving HOLD, because its contents are
      // only ever read on the HOLD -> FETCH release.
      pc        <= redirect_pc;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_bad) begin
        misaligned <= 1'b1;
        state      <= ST_HALT;
      end else begin
        state <= ST_FETCH;
      end
`else
      state <= redirect_bad ? ST_BOOT : ST_FETCH;
`endif
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (accepted) begin
            pc <= pc + 32'd4;
            if (stall) begin
              buf_instr <= imem_rdata;
              buf_pc    <= pc;
              state     <= ST_HOLD;
            end else begin
              instr_out <= imem_rdata;
              pc_out    <= pc;
              valid_out <= 1'b1;
            end
          end else if (!stall) begin
            // Nothing arrived and decode is draining: insert a bubble.
            // pc_out keeps the last real PC.
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            instr_out <= buf_instr;
            pc_out    <= buf_pc;
            valid_out <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. dut0 uses the default RESET_PC and walks
// through boot, streaming, bubbles, a stall with buffering, a redirect out
// of HOLD, a misaligned redirect and an asynchronous reset taken mid-stall.
// dut1 uses RESET_PC = 32'hFFFF_FFF8 and streams across the 32-bit wrap.
// Both memories return address-tagged words: {8'hC0, addr[23:0]}.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {8'hC0, a[23:0]};
  endfunction

  // dut0 signals
  logic        imem_req0, imem_ready0, stall0, branch_taken0;
  logic [31:0] imem_addr0, imem_rdata0, branch_target0;
  logic [31:0] instr_out0, pc_out0;
  logic        valid_out0;

  // dut1 signals
  logic        imem_req1, imem_ready1, stall1, branch_taken1;
  logic [31:0] imem_addr1, imem_rdata1, branch_target1;
  logic [31:0] instr_out1, pc_out1;
  logic        valid_out1;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned0, misaligned1;
`endif

  assign imem_rdata0 = word_at(imem_addr0);
  assign imem_rdata1 = word_at(imem_addr1);

  fetch_stage dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req0),
    .imem_addr     (imem_addr0),
    .imem_ready    (imem_ready0),
    .imem_rdata    (imem_rdata0),
    .stall         (stall0),
    .branch_taken  (branch_taken0),
    .branch_target (branch_target0),
    .instr_out     (instr_out0),
    .pc_out        (pc_out0),
    .valid_out     (valid_out0)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misaligned    (misaligned0)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req1),
    .imem_addr     (imem_addr1),
    .imem_ready    (imem_ready1),
    .imem_rdata    (imem_rdata1),
    .stall         (stall1),
    .branch_taken  (branch_taken1),
    .branch_target (branch_target1),
    .instr_out     (instr_out1),
    .pc_out        (pc_out1),
    .valid_out     (valid_out1)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misaligned    (misaligned1)
`endif
  );

  // scoreboard counters
  int checks;
  int errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // driver: advance one clock, then settle past the edge before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_ready0    = 1'b1;
    stall0         = 1'b0;
    branch_taken0  = 1'b0;
    branch_target0 = 32'h0;
    imem_ready1    = 1'b1;
    stall1         = 1'b0;
    branch_taken1  = 1'b0;
    branch_target1 = 32'h0;
    checks         = 0;
    errors         = 0;

    step();
    // reset state
    check_eq("rst_req",    {31'b0, imem_req0},  32'd0);
    check_eq("rst_instr",  instr_out0,          NOP);
    check_eq("rst_pc_out", pc_out0,             32'd0);
    check_eq("rst_valid",  {31'b0, valid_out0}, 32'd0);
    check_eq("rst_addr",   imem_addr0,          32'd0);
    check_eq("rst_addr1",  imem_addr1,          32'hFFFF_FFF8);
    check_eq("rst_req1",   {31'b0, imem_req1},  32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("rst_mis",    {31'b0, misaligned0}, 32'd0);
`endif
    rst_n = 1'b1;

    // E1: BOOT -> FETCH, nothing fetched yet
    step();
    check_eq("boot_req",   {31'b0, imem_req0},  32'd1);
    check_eq("boot_addr",  imem_addr0,          32'd0);
    check_eq("boot_valid", {31'b0, valid_out0}, 32'd0);
    check_eq("boot_addr1", imem_addr1,          32'hFFFF_FFF8);

    // E2..E3: streaming, one word per cycle
    step();
    check_eq("s0_instr",   instr_out0,          word_at(32'd0));
    check_eq("s0_pc",      pc_out0,             32'd0);
    check_eq("s0_valid",   {31'b0, valid_out0}, 32'd1);
    check_eq("w0_instr1",  instr_out1,          32'hC0FF_FFF8);
    check_eq("w0_pc1",     pc_out1,             32'hFFFF_FFF8);
    step();
    check_eq("s1_instr",   instr_out0,          word_at(32'd4));
    check_eq("s1_pc",      pc_out0,             32'd4);
    check_eq("w1_instr1",  instr_out1,          32'hC0FF_FFFC);
    check_eq("w1_pc1",     pc_out1,             32'hFFFF_FFFC);
    check_eq("w1_addr1",   imem_addr1,          32'h0000_0000);

    // E4..E5: memory not ready at pc=8 -> two bubbles
    imem_ready0 = 1'b0;
    step();
    check_eq("b0_instr",   instr_out0,          NOP);
    check_eq("b0_valid",   {31'b0, valid_out0}, 32'd0);
    check_eq("b0_pc_hold", pc_out0,             32'd4);
    check_eq("b0_addr",    imem_addr0,          32'd8);
    check_eq("w2_instr1",  instr_out1,          32'hC000_0000);
    check_eq("w2_pc1",     pc_out1,             32'h0000_0000);
    step();
    check_eq("b1_instr",   instr_out0,          NOP);
    check_eq("b1_addr",    imem_addr0,          32'd8);

    // E6: resumes with word@8
    imem_ready0 = 1'b1;
    step();
    check_eq("r_instr",    instr_out0,          word_at(32'd8));
    check_eq("r_pc",       pc_out0,             32'd8);
    check_eq("r_valid",    {31'b0, valid_out0}, 32'd1);

    // E7..E9: stall, word@12 goes into the buffer
    stall0 = 1'b1;
    step();
    check_eq("st0_instr",  instr_out0,          word_at(32'd8));
    check_eq("st0_pc",     pc_out0,             32'd8);
    check_eq("st0_req",    {31'b0, imem_req0},  32'd0);
    step();
    check_eq("st1_instr",  instr_out0,          word_at(32'd8));
    check_eq("st1_req",    {31'b0, imem_req0},  32'd0);
    step();
    check_eq("st2_valid",  {31'b0, valid_out0}, 32'd1);
    check_eq("st2_req",    {31'b0, imem_req0},  32'd0);

    // E10..E11: release, buffered word then the next fetch
    stall0 = 1'b0;
    step();
    check_eq("rel_instr",  instr_out0,          word_at(32'd12));
    check_eq("rel_pc",     pc_out0,             32'd12);
    check_eq("rel_req",    {31'b0, imem_req0},  32'd1);
    check_eq("rel_addr",   imem_addr0,          32'd16);
    step();
    check_eq("nx_instr",   instr_out0,          word_at(32'd16));
    check_eq("nx_pc",      pc_out0,             32'd16);

    // E12: stall again, word@20 is buffered
    stall0 = 1'b1;
    step();
    check_eq("h_instr",    instr_out0,          word_at(32'd16));
    check_eq("h_req",      {31'b0, imem_req0},  32'd0);

    // E13: redirect during HOLD while stalled
    branch_taken0  = 1'b1;
    branch_target0 = 32'h0000_0100;
    step();
    check_eq("br_valid",   {31'b0, valid_out0}, 32'd0);
    check_eq("br_instr",   instr_out0,          NOP);
    check_eq("br_addr",    imem_addr0,          32'h0000_0100);
    check_eq("br_req",     {31'b0, imem_req0},  32'd1);

    // E14..E15: fetch from the target, buffered word@20 never appears
    branch_taken0 = 1'b0;
    stall0        = 1'b0;
    step();
    check_eq("bt0_instr",  instr_out0,          word_at(32'h100));
    check_eq("bt0_pc",     pc_out0,             32'h100);
    step();
    check_eq("bt1_instr",  instr_out0,          word_at(32'h104));
    check_eq("bt1_pc",     pc_out0,             32'h104);

    // E16: misaligned redirect target
    branch_taken0  = 1'b1;
    branch_target0 = 32'h0000_0102;
    step();
    branch_taken0 = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("mis_flag",   {31'b0, misaligned0}, 32'd1);
    check_eq("mis_addr",   imem_addr0,           32'h0000_0102);
    check_eq("mis_req",    {31'b0, imem_req0},   32'd0);
    check_eq("mis_valid",  {31'b0, valid_out0},  32'd0);
    // a later redirect is ignored while halted
    branch_taken0  = 1'b1;
    branch_target0 = 32'h0000_0200;
    step();
    branch_taken0 = 1'b0;
    check_eq("halt_addr",  imem_addr0,           32'h0000_0102);
    check_eq("halt_req",   {31'b0, imem_req0},   32'd0);
    check_eq("halt_flag",  {31'b0, misaligned0}, 32'd1);
    check_eq("halt_instr", instr_out0,           NOP);
`else
    check_eq("mal_addr",   imem_addr0,           32'h0000_0100);
    check_eq("mal_valid",  {31'b0, valid_out0},  32'd0);
    check_eq("mal_instr",  instr_out0,           NOP);
    check_eq("mal_req",    {31'b0, imem_req0},   32'd1);
    step();
    check_eq("mal_fetch",  instr_out0,           word_at(32'h100));
    check_eq("mal_pc",     pc_out0,              32'h100);
    check_eq("mal_valid1", {31'b0, valid_out0},  32'd1);
`endif

    // asynchronous reset taken mid-stall discards everything at once
    stall0 = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("ar_req",     {31'b0, imem_req0},  32'd0);
    check_eq("ar_instr",   instr_out0,          NOP);
    check_eq("ar_pc_out",  pc_out0,             32'd0);
    check_eq("ar_valid",   {31'b0, valid_out0}, 32'd0);
    check_eq("ar_addr",    imem_addr0,          32'd0);
    check_eq("ar_addr1",   imem_addr1,          32'hFFFF_FFF8);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("ar_mis",     {31'b0, misaligned0}, 32'd0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
